s382_bist_sequencer: RTL and testbench

Built-in self-test sequencer for the s382 sequential benchmark core in the SFQ benchmark set. It flushes the core's 21-flop state with a constant pattern, then drives pseudo-random stimulus onto G200/G201/G202 from a 16-bit LFSR. It compacts the six core outputs (G301–G306) into a 16-bit MISR signature, aligned to the core's gate-level pipeline depth. It sits between the test host and one s382 instance and reports a signature and a pass/fail verdict.

---
 rtl/s382_bist_sequencer.sv | 94 +++++++++
 tb/tb_s382_bist_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/s382_bist_sequencer.sv
// s382_bist_sequencer: flushes an s382 core, drives it with LFSR stimulus and compacts its outputs into a MISR.
module s382_bist_sequencer #(
  parameter int          PATTERNS  = 256,
  parameter int          DEPTH     = 8,
  parameter int          FLUSH_CYC = 32,
  parameter logic [2:0]  FLUSH_PAT = 3'b000,
  parameter logic [15:0] SEED      = 16'h0001
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] EXP_SIG,
  input  logic [5:0]  DUT_OUT,
  output logic [2:0]  DUT_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIG
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  if (PATTERNS < 1 || PATTERNS > 65535 || DEPTH < 1 || DEPTH > 63 || FLUSH_CYC < 1 || FLUSH_CYC > 255) begin : g_bad_params
    $error("s382_bist_sequencer: parameter out of range");
  end
  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d, lfsr_nxt;
  logic [15:0]        misr_q, misr_d;
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [2:0]         dut_in_q, dut_in_d;
  logic               pass_q, pass_d;
  always_comb begin
    lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    dut_in_d = FLUSH_PAT;
    // the delayed valid lines up each capture with the core's pipeline depth
    vld_d    = (vld_q << 1) | DEPTH'(state_q == S_RUN);
    misr_d   = vld_q[DEPTH-1] ? ({misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]} ^ {10'b0, DUT_OUT}) : misr_q;
    case (state_q)
      S_IDLE, S_DONE: if (START) begin
        state_d = S_FLUSH;
        cnt_d   = 16'(FLUSH_CYC - 1);
        lfsr_d  = SEED_EFF;
        misr_d  = '0;
      end
      S_FLUSH: if (cnt_q == '0) begin
        state_d  = S_RUN;
        cnt_d    = 16'(PATTERNS - 1);
        dut_in_d = lfsr_q[2:0];
      end else cnt_d = cnt_q - 16'd1;
      S_RUN: begin
        lfsr_d = lfsr_nxt;
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          cnt_d   = 16'(DEPTH - 1);
        end else begin
          cnt_d    = cnt_q - 16'd1;
          dut_in_d = lfsr_nxt[2:0];
        end
      end
      S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
               else cnt_d = cnt_q - 16'd1;
      default: state_d = S_IDLE;
    endcase
    // verdict uses the signature including the final capture that lands on DONE entry
    pass_d = (state_d == S_DONE) && ((state_q == S_DONE) ? pass_q : (misr_d == EXP_SIG));
  end
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= SEED_EFF;
      misr_q   <= '0;
      vld_q    <= '0;
      dut_in_q <= FLUSH_PAT;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      vld_q    <= vld_d;
      dut_in_q <= dut_in_d;
      pass_q   <= pass_d;
    end
  end
  assign DUT_IN = dut_in_q;
  assign BUSY   = (state_q == S_FLUSH) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign DONE   = (state_q == S_DONE);
  assign PASS   = pass_q;
  assign SIG    = misr_q;
endmodule

// File: tb/tb_s382_bist_sequencer.sv
// tb_s382_bist_sequencer: directed tests over four sequencer instances with different run shapes.
module tb_s382_bist_sequencer;
  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        start [4];
  logic [15:0] exp_sig [4];
  logic [5:0]  dout [3];
  logic [5:0]  core_out;
  logic [2:0]  din [4];
  logic        busy [4];
  logic        done [4];
  logic        pass [4];
  logic [15:0] sig [4];
  logic [5:0]  p0 = '0, p1 = '0, p2 = '0;
  int checks = 0;
  int failures = 0;
  always #5 CK = ~CK;
  s382_bist_sequencer #(.PATTERNS(4), .DEPTH(2), .FLUSH_CYC(2), .FLUSH_PAT(3'b000), .SEED(16'h0001)) u_a (
    .CK(CK), .RST(RST), .START(start[0]), .EXP_SIG(exp_sig[0]), .DUT_OUT(dout[0]),
    .DUT_IN(din[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .SIG(sig[0]));
  s382_bist_sequencer #(.PATTERNS(2), .DEPTH(4), .FLUSH_CYC(2), .FLUSH_PAT(3'b000), .SEED(16'h0001)) u_b (
    .CK(CK), .RST(RST), .START(start[1]), .EXP_SIG(exp_sig[1]), .DUT_OUT(dout[1]),
    .DUT_IN(din[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .SIG(sig[1]));
  s382_bist_sequencer #(.PATTERNS(1), .DEPTH(4), .FLUSH_CYC(2), .FLUSH_PAT(3'b000), .SEED(16'h0001)) u_c (
    .CK(CK), .RST(RST), .START(start[2]), .EXP_SIG(exp_sig[2]), .DUT_OUT(dout[2]),
    .DUT_IN(din[2]), .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .SIG(sig[2]));
  s382_bist_sequencer #(.PATTERNS(20), .DEPTH(3), .FLUSH_CYC(3), .FLUSH_PAT(3'b000), .SEED(16'hACE1)) u_d (
    .CK(CK), .RST(RST), .START(start[3]), .EXP_SIG(exp_sig[3]), .DUT_OUT(core_out),
    .DUT_IN(din[3]), .BUSY(busy[3]), .DONE(done[3]), .PASS(pass[3]), .SIG(sig[3]));
  function automatic logic [5:0] core_fn(input logic [2:0] x);
    return {x, x ^ 3'b101};
  endfunction
  // stand-in core: three-stage pipeline, so each pattern's response appears 3 cycles later
  always @(posedge CK) begin
    p0 <= core_fn(din[3]);
    p1 <= p0;
    p2 <= p1;
  end
  assign core_out = p2;
  function automatic logic [15:0] model_sig();
    logic [15:0] l;
    logic [15:0] m;
    l = 16'hACE1;
    m = '0;
    for (int k = 0; k < 20; k++) begin
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, core_fn(l[2:0])};
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return m;
  endfunction
  task automatic step();
    @(posedge CK);
    #1;
  endtask
  task automatic run_to_done(input int i, output int cyc);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
    cyc = 1;
    while (!done[i] && cyc < 200) begin
      step();
      cyc++;
    end
  endtask
  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    for (int c = 0; c < 10; c++) step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy[i]); end
      checks++; if (done[i] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d] got=%b exp=0", i, done[i]); end
      checks++; if (pass[i] !== 1'b0) begin failures++; $display("FAIL reset_pass[%0d] got=%b exp=0", i, pass[i]); end
      checks++; if (sig[i] !== 16'h0000) begin failures++; $display("FAIL reset_sig[%0d] got=%h exp=0000", i, sig[i]); end
      checks++; if (din[i] !== 3'b000) begin failures++; $display("FAIL reset_dut_in[%0d] got=%b exp=000", i, din[i]); end
    end
  endtask
  task automatic test_stimulus();
    logic [2:0] exp_in [8];
    exp_in = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000};
    dout[0] = 6'h01;
    exp_sig[0] = 16'h000F;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++; if (din[0] !== exp_in[c]) begin failures++; $display("FAIL stim_dut_in cyc=%0d got=%b exp=%b", c + 1, din[0], exp_in[c]); end
      checks++; if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin failures++; $display("FAIL stim_busy cyc=%0d got=%b%b exp=10", c + 1, busy[0], done[0]); end
      step();
    end
    checks++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin failures++; $display("FAIL stim_done_at_9 got=%b%b exp=01", busy[0], done[0]); end
    checks++; if (sig[0] !== 16'h000F) begin failures++; $display("FAIL stim_sig got=%h exp=000f", sig[0]); end
    checks++; if (pass[0] !== 1'b1) begin failures++; $display("FAIL stim_pass got=%b exp=1", pass[0]); end
    step();
    checks++; if (sig[0] !== 16'h000F || done[0] !== 1'b1) begin failures++; $display("FAIL done_hold got=%h/%b exp=000f/1", sig[0], done[0]); end
  endtask
  task automatic test_restart_ignore();
    int n;
    start[0] = 1'b1;
    step();
    checks++; if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin failures++; $display("FAIL restart_state got=%b%b exp=10", busy[0], done[0]); end
    checks++; if (sig[0] !== 16'h0000) begin failures++; $display("FAIL restart_sig got=%h exp=0000", sig[0]); end
    checks++; if (pass[0] !== 1'b0) begin failures++; $display("FAIL restart_pass got=%b exp=0", pass[0]); end
    n = 0;
    while (busy[0] && n < 50) begin
      if (n == 4) start[0] = 1'b0;
      step();
      n++;
    end
    start[0] = 1'b0;
    checks++; if (n !== 8) begin failures++; $display("FAIL busy_len got=%0d exp=8", n); end
    checks++; if (done[0] !== 1'b1 || sig[0] !== 16'h000F) begin failures++; $display("FAIL ignore_done got=%b/%h exp=1/000f", done[0], sig[0]); end
  endtask
  task automatic test_alignment();
    int cyc;
    dout[1] = 6'h01;
    exp_sig[1] = 16'h0003;
    run_to_done(1, cyc);
    checks++; if (cyc !== 9) begin failures++; $display("FAIL align_latency got=%0d exp=9", cyc); end
    checks++; if (sig[1] !== 16'h0003) begin failures++; $display("FAIL align_sig got=%h exp=0003", sig[1]); end
    checks++; if (pass[1] !== 1'b1) begin failures++; $display("FAIL align_pass got=%b exp=1", pass[1]); end
    dout[1] = 6'h00;
    exp_sig[1] = 16'h0000;
    run_to_done(1, cyc);
    checks++; if (sig[1] !== 16'h0000) begin failures++; $display("FAIL zero_sig got=%h exp=0000", sig[1]); end
    checks++; if (pass[1] !== 1'b1) begin failures++; $display("FAIL zero_pass got=%b exp=1", pass[1]); end
    exp_sig[1] = 16'h0001;
    run_to_done(1, cyc);
    checks++; if (pass[1] !== 1'b0) begin failures++; $display("FAIL mismatch_pass got=%b exp=0", pass[1]); end
  endtask
  task automatic test_latency();
    int offs [3];
    logic [15:0] exp_s [3];
    int cyc;
    offs = '{7, 6, 8};
    exp_s = '{16'h0001, 16'h0000, 16'h0000};
    exp_sig[2] = 16'h0001;
    dout[2] = 6'h00;
    for (int j = 0; j < 3; j++) begin
      start[2] = 1'b1;
      step();
      start[2] = 1'b0;
      for (int c = 1; c < offs[j]; c++) step();
      dout[2] = 6'h01;
      step();
      dout[2] = 6'h00;
      cyc = 0;
      while (!done[2] && cyc < 100) begin
        step();
        cyc++;
      end
      checks++; if (sig[2] !== exp_s[j]) begin failures++; $display("FAIL latency_sig off=%0d got=%h exp=%h", offs[j], sig[2], exp_s[j]); end
      checks++; if (pass[2] !== (exp_s[j] == 16'h0001)) begin failures++; $display("FAIL latency_pass off=%0d got=%b exp=%b", offs[j], pass[2], exp_s[j] == 16'h0001); end
    end
  endtask
  task automatic test_rst_midrun();
    int cyc;
    logic [15:0] ref_sig;
    ref_sig = model_sig();
    exp_sig[3] = ref_sig;
    start[3] = 1'b1;
    step();
    start[3] = 1'b0;
    for (int c = 1; c < 10; c++) step();
    checks++; if (busy[3] !== 1'b1) begin failures++; $display("FAIL midrun_busy got=%b exp=1", busy[3]); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++; if (busy[3] !== 1'b0 || done[3] !== 1'b0) begin failures++; $display("FAIL rst_state got=%b%b exp=00", busy[3], done[3]); end
    checks++; if (sig[3] !== 16'h0000) begin failures++; $display("FAIL rst_sig got=%h exp=0000", sig[3]); end
    checks++; if (din[3] !== 3'b000) begin failures++; $display("FAIL rst_dut_in got=%b exp=000", din[3]); end
    run_to_done(3, cyc);
    checks++; if (cyc !== 27) begin failures++; $display("FAIL model_latency got=%0d exp=27", cyc); end
    checks++; if (sig[3] !== ref_sig) begin failures++; $display("FAIL model_sig got=%h exp=%h", sig[3], ref_sig); end
    checks++; if (pass[3] !== 1'b1) begin failures++; $display("FAIL model_pass got=%b exp=1", pass[3]); end
    RST = 1'b1;
    start[0] = 1'b1;
    step();
    RST = 1'b0;
    start[0] = 1'b0;
    step();
    checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin failures++; $display("FAIL rst_beats_start got=%b%b exp=00", busy[0], done[0]); end
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      exp_sig[i] = '0;
    end
    for (int i = 0; i < 3; i++) dout[i] = '0;
    test_reset();
    test_stimulus();
    test_restart_ignore();
    test_alignment();
    test_latency();
    test_rst_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
